// File: rtl/skolem_sweep_checker.sv
// ---------------------------------------------------------------------------
// skolem_sweep_checker
//
// Purpose:
//   Exhaustive sequencer and checker for a W-bit Skolem function block that
//   solves the bvult/bvurem invertibility problem: find x with (x urem s) <u t.
//   Every (s,t) pair is driven into an external Skolem instance. The returned
//   x is latched, x urem s is recomputed with a serial restoring divider, and
//   vacuous, passing and failing vectors are tallied.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   start          one-cycle pulse; begins a sweep when idle
//   busy           sweep in progress (APPLY, DIV, CHECK)
//   done           one-cycle pulse at sweep end
//   pass           fail_cnt==0; valid from done, held until next start
//   sk_s, sk_t     operands driven to the Skolem instance
//   sk_x           x returned by the Skolem instance
//   vec_cnt        vectors checked
//   vac_cnt        vectors with t==0 (condition false, check skipped)
//   fail_cnt       vectors with t!=0 where (x urem s) <u t is false
//   fail_seen      sticky; at least one failure this sweep
//   first_fail_vec {t,s} of the first failure
//   first_fail_x   x of the first failure
//
// Parameters:
//   W    operand width of s, t and x (W >= 2)
//   LAT  Skolem instance latency in clk cycles (0 = combinational)
//
// Optional feature (macro SKOLEM_CHECK_STOP_ON_FAIL_EN):
//   When defined, the first failing CHECK ends the sweep immediately.
//   When undefined, all 2^(2W) vectors are always covered.
// ---------------------------------------------------------------------------
module skolem_sweep_checker #(
    parameter int W   = 4,
    parameter int LAT = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [W-1:0]   sk_s,
    output logic [W-1:0]   sk_t,
    input  logic [W-1:0]   sk_x,
    output logic [2*W:0]   vec_cnt,
    output logic [2*W:0]   vac_cnt,
    output logic [2*W:0]   fail_cnt,
    output logic           fail_seen,
    output logic [2*W-1:0] first_fail_vec,
    output logic [W-1:0]   first_fail_x
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        DIV,
        CHECK,
        DONE
    } state_t;

    // Latency counter width: at least one bit even when LAT is 0.
    localparam int LW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam int DW = $clog2(W) + 1;

    localparam logic [LW-1:0]  LAT_LAST = LW'(LAT);
    localparam logic [LW-1:0]  LAT_ONE  = LW'(1);
    localparam logic [DW-1:0]  DIV_LAST = DW'(W - 1);
    localparam logic [DW-1:0]  DIV_ONE  = DW'(1);
    localparam logic [2*W:0]   CNT_ONE  = (2*W+1)'(1);
    localparam logic [2*W-1:0] V_ONE    = (2*W)'(1);

    state_t state;
    state_t state_next;

    logic [2*W-1:0] v;
    logic [2*W-1:0] v_next;
    logic [LW-1:0]  lat_cnt;
    logic [DW-1:0]  div_cnt;
    logic [W-1:0]   xr;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;

    logic [W:0]     rem_shift;
    logic [W:0]     rem_diff;
    logic           rem_fits;
    logic [W-1:0]   rem_final;
    logic           apply_last;
    logic           div_last;
    logic           v_last;
    logic           vacuous;
    logic           check_fail;
    logic           stop_now;

    // Decode helpers shared by the FSM and the datapath.
    always_comb begin
        apply_last = (lat_cnt == LAT_LAST);
        div_last   = (div_cnt == DIV_LAST);
        v_last     = &v;
        v_next     = v + V_ONE;

        // The partial remainder briefly needs W+1 bits after the shift. The
        // borrow of the trial subtraction decides the quotient bit; while
        // s != 0 the kept remainder is always below s, so W bits hold it.
        rem_shift  = {rem, quo[W-1]};
        rem_diff   = rem_shift - {1'b0, sk_s};
        rem_fits   = ~rem_diff[W];

        // x urem 0 = x, regardless of what the divider produced.
        rem_final  = (sk_s == '0) ? xr : rem;

        vacuous    = (sk_t == '0);
        check_fail = ~vacuous && ~(rem_final < sk_t);
`ifdef SKOLEM_CHECK_STOP_ON_FAIL_EN
        stop_now   = check_fail;
`else
        stop_now   = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                busy = 1'b1;
                if (apply_last) begin
                    state_next = DIV;
                end
            end
            DIV: begin
                busy = 1'b1;
                if (div_last) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (v_last || stop_now) begin
                    state_next = DONE;
                end else begin
                    state_next = APPLY;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: vector index, operands, latency wait, divider and tallies.
    // sk_s/sk_t only change on the transition into APPLY so the Skolem
    // instance sees stable operands for the whole vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            v              <= '0;
            sk_s           <= '0;
            sk_t           <= '0;
            lat_cnt        <= '0;
            div_cnt        <= '0;
            xr             <= '0;
            quo            <= '0;
            rem            <= '0;
            vec_cnt        <= '0;
            vac_cnt        <= '0;
            fail_cnt       <= '0;
            fail_seen      <= 1'b0;
            first_fail_vec <= '0;
            first_fail_x   <= '0;
            pass           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        v              <= '0;
                        sk_s           <= '0;
                        sk_t           <= '0;
                        lat_cnt        <= '0;
                        vec_cnt        <= '0;
                        vac_cnt        <= '0;
                        fail_cnt       <= '0;
                        fail_seen      <= 1'b0;
                        first_fail_vec <= '0;
                        first_fail_x   <= '0;
                        pass           <= 1'b0;
                    end
                end
                APPLY: begin
                    if (apply_last) begin
                        xr      <= sk_x;
                        quo     <= sk_x;
                        rem     <= '0;
                        div_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_ONE;
                    end
                end
                DIV: begin
                    // One restoring step per cycle; dividend bits shift out
                    // of the top of quo while quotient bits enter the bottom.
                    if (rem_fits) begin
                        rem <= rem_diff[W-1:0];
                    end else begin
                        rem <= rem_shift[W-1:0];
                    end
                    quo     <= {quo[W-2:0], rem_fits};
                    div_cnt <= div_cnt + DIV_ONE;
                end
                CHECK: begin
                    vec_cnt <= vec_cnt + CNT_ONE;
                    if (vacuous) begin
                        vac_cnt <= vac_cnt + CNT_ONE;
                    end else if (check_fail) begin
                        fail_cnt <= fail_cnt + CNT_ONE;
                        if (!fail_seen) begin
                            fail_seen      <= 1'b1;
                            first_fail_vec <= {sk_t, sk_s};
                            first_fail_x   <= xr;
                        end
                    end
                    if (v_last || stop_now) begin
                        pass <= ~(fail_seen | check_fail);
                    end else begin
                        v       <= v_next;
                        sk_s    <= v_next[W-1:0];
                        sk_t    <= v_next[2*W-1:W];
                        lat_cnt <= '0;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_skolem_sweep_checker
//
// Directed bench for skolem_sweep_checker with W=4. Two instances are used:
// dut0 with LAT=0 fed by a combinational Skolem model, dut1 with LAT=2 fed
// by a registered pipeline model (2 stages = correct, 3 stages = too slow).
// ---------------------------------------------------------------------------
module tb_skolem_sweep_checker;

    localparam int W = 4;

`ifdef SKOLEM_CHECK_STOP_ON_FAIL_EN
    localparam int EXP_VEC_S3T1 = 20;
    localparam int EXP_VEC_X5   = 17;
    localparam int EXP_FAIL_X5  = 1;
`else
    localparam int EXP_VEC_S3T1 = 256;
    localparam int EXP_VEC_X5   = 256;
    localparam int EXP_FAIL_X5  = 5;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    logic         busy0, done0, pass0, fs0;
    logic [W-1:0] s0, t0, x0, ffx0;
    logic [2*W:0] vec0, vac0, fail0;
    logic [2*W-1:0] ffv0;

    logic         busy1, done1, pass1, fs1;
    logic [W-1:0] s1, t1, x1, ffx1;
    logic [2*W:0] vec1, vac1, fail1;
    logic [2*W-1:0] ffv1;

    skolem_sweep_checker #(.W(W), .LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .pass(pass0), .sk_s(s0), .sk_t(t0), .sk_x(x0), .vec_cnt(vec0),
        .vac_cnt(vac0), .fail_cnt(fail0), .fail_seen(fs0),
        .first_fail_vec(ffv0), .first_fail_x(ffx0)
    );

    skolem_sweep_checker #(.W(W), .LAT(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .pass(pass1), .sk_s(s1), .sk_t(t1), .sk_x(x1), .vec_cnt(vec1),
        .vac_cnt(vac1), .fail_cnt(fail1), .fail_seen(fs1),
        .first_fail_vec(ffv1), .first_fail_x(ffx1)
    );

    // Combinational Skolem models for dut0.
    //   0: x = 0 (correct)
    //   1: x = 0 except (s=3,t=1) -> 2 (one fault)
    //   2: x = 5 when s = 0, else 0
    int mode0 = 0;
    always_comb begin
        x0 = '0;
        if (mode0 == 1 && s0 == 4'd3 && t0 == 4'd1) x0 = 4'd2;
        if (mode0 == 2 && s0 == 4'd0) x0 = 4'd5;
    end

    // Registered model for dut1: x = s (s urem s = 0, and 0 when s = 0).
    logic [W-1:0] p1 = '0, p2 = '0, p3 = '0;
    bit three_stage = 1'b0;
    always @(posedge clk) begin
        p1 <= s1;
        p2 <= p1;
        p3 <= p2;
    end
    assign x1 = three_stage ? p3 : p2;

    // Observation mux so one sweep task serves both instances.
    int sel = 0;
    logic         m_busy, m_done, m_pass, m_fs;
    logic [2*W:0] m_vec, m_vac, m_fail;
    logic [2*W-1:0] m_ffv;
    logic [W-1:0] m_ffx;
    always_comb begin
        m_busy = (sel == 0) ? busy0 : busy1;
        m_done = (sel == 0) ? done0 : done1;
        m_pass = (sel == 0) ? pass0 : pass1;
        m_fs   = (sel == 0) ? fs0   : fs1;
        m_vec  = (sel == 0) ? vec0  : vec1;
        m_vac  = (sel == 0) ? vac0  : vac1;
        m_fail = (sel == 0) ? fail0 : fail1;
        m_ffv  = (sel == 0) ? ffv0  : ffv1;
        m_ffx  = (sel == 0) ? ffx0  : ffx1;
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Pulse start on the selected instance for one clock.
    task automatic applyStimulus(input int which);
        @(negedge clk);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Run one sweep; cycles counts from the first APPLY cycle to done.
    // A start pulse is injected at cycle 'poke' (negative = none).
    task automatic runSweep(input int which, input int poke, output int cycles);
        int k;
        bit timed_out;
        sel = which;
        applyStimulus(which);
        checkOutput("busy after start", m_busy, 1);
        k = 0;
        timed_out = 1'b0;
        while (!m_done && !timed_out) begin
            if (k == poke + 1) begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            if (k == poke) begin
                if (which == 0) start0 = 1'b1; else start1 = 1'b1;
            end
            @(negedge clk);
            k++;
            if (k > 5000) timed_out = 1'b1;
        end
        start0 = 1'b0;
        start1 = 1'b0;
        checkOutput("sweep timeout", timed_out, 0);
        checkOutput("busy at done", m_busy, 0);
        cycles = k;
    endtask

    initial begin
        int cyc;
        int k;
        bit done_seen;

        $display("[TB] start");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        checkOutput("rst busy", busy0, 0);
        checkOutput("rst done", done0, 0);
        checkOutput("rst pass", pass0, 0);
        checkOutput("rst vec", vec0, 0);
        checkOutput("rst vac", vac0, 0);
        checkOutput("rst fail", fail0, 0);
        checkOutput("rst fail_seen", fs0, 0);
        checkOutput("rst sk_s", s0, 0);
        checkOutput("rst sk_t", t0, 0);
        checkOutput("rst ffv", ffv0, 0);
        checkOutput("rst ffx", ffx0, 0);

        // Correct model x=0, with a start pulse injected mid-sweep.
        mode0 = 0;
        runSweep(0, 300, cyc);
        checkOutput("x0 cycles", cyc, 1536);
        checkOutput("x0 vec", vec0, 256);
        checkOutput("x0 vac", vac0, 16);
        checkOutput("x0 fail", fail0, 0);
        checkOutput("x0 pass", pass0, 1);
        checkOutput("x0 fail_seen", fs0, 0);
        @(negedge clk);
        checkOutput("done one pulse", done0, 0);
        checkOutput("pass held", pass0, 1);

        // Single fault at (s=3,t=1).
        mode0 = 1;
        runSweep(0, -1, cyc);
        checkOutput("s3t1 vec", vec0, EXP_VEC_S3T1);
        checkOutput("s3t1 vac", vac0, 16);
        checkOutput("s3t1 fail", fail0, 1);
        checkOutput("s3t1 ffv", ffv0, 8'h13);
        checkOutput("s3t1 ffx", ffx0, 4'h2);
        checkOutput("s3t1 pass", pass0, 0);
        checkOutput("s3t1 fail_seen", fs0, 1);

        // x=5 when s=0: urem-by-zero boundary.
        mode0 = 2;
        runSweep(0, -1, cyc);
        checkOutput("x5 vec", vec0, EXP_VEC_X5);
        checkOutput("x5 fail", fail0, EXP_FAIL_X5);
        checkOutput("x5 ffv", ffv0, 8'h10);
        checkOutput("x5 ffx", ffx0, 4'h5);
        checkOutput("x5 pass", pass0, 0);

        // Reset mid-sweep at v=100 (t=6, s=4).
        mode0 = 0;
        applyStimulus(0);
        k = 0;
        while (!(t0 == 4'd6 && s0 == 4'd4) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        checkOutput("reach v100", k < 2000, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst busy", busy0, 0);
        checkOutput("midrst vec", vec0, 0);
        checkOutput("midrst vac", vac0, 0);
        checkOutput("midrst sk_t", t0, 0);
        done_seen = 1'b0;
        repeat (20) begin
            if (done0) done_seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("midrst no done", done_seen, 0);
        runSweep(0, -1, cyc);
        checkOutput("after rst cycles", cyc, 1536);
        checkOutput("after rst vec", vec0, 256);
        checkOutput("after rst pass", pass0, 1);

        // LAT=2 with a correctly pipelined model.
        three_stage = 1'b0;
        runSweep(1, -1, cyc);
        checkOutput("lat2 cycles", cyc, 2048);
        checkOutput("lat2 vec", vec1, 256);
        checkOutput("lat2 fail", fail1, 0);
        checkOutput("lat2 pass", pass1, 1);

        // LAT=2 with a model one stage too slow.
        three_stage = 1'b1;
        runSweep(1, -1, cyc);
        checkOutput("lat3 fails seen", fail1 != 0, 1);
        checkOutput("lat3 pass", pass1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
